// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that streams operands through one 4-bit
// carry-lookahead slice, one nibble per clock, LSB nibble first.
// Ports: clk_i, reset_i (async, active-high); start_i/a_i/b_i/cy_in_i request;
// busy_o, done_o handshake; sum_o, cy_out_o, ovf_o registered result.

// carry_lookahead_adder: combinational 4-bit carry-lookahead slice.
// Ports: a_i, b_i, cy_in_i operands; sum_o, cy_out_o result.
module carry_lookahead_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cy_in_i,
  output logic [3:0] sum_o,
  output logic       cy_out_o
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = a_i & b_i;
  assign p = a_i ^ b_i;
  assign c[0] = cy_in_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign sum_o    = p ^ c[3:0];
  assign cy_out_o = c[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cy_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cy_out_o,
  output logic             ovf_o
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = NIB > 1 ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, shadow_q, shadow_d;
  logic             c_q;
  logic [IW-1:0]    idx_q;
  logic [3:0]       nib_a, nib_b, s_sum;
  logic             s_co, last, ovf_d, accept;
  assign nib_a  = a_q[4*idx_q +: 4];
  assign nib_b  = b_q[4*idx_q +: 4];
  assign last   = idx_q == IW'(NIB - 1);
  // Carry into the MSB is a^b^sum at that bit; overflow is it XOR carry out.
  assign ovf_d  = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ s_sum[3] ^ s_co;
  assign accept = start_i && (state_q == IDLE || state_q == DONE);
  carry_lookahead_adder u_cla (
    .a_i     (nib_a),
    .b_i     (nib_b),
    .cy_in_i (c_q),
    .sum_o   (s_sum),
    .cy_out_o(s_co)
  );
  always_comb begin
    shadow_d = shadow_q;
    shadow_d[4*idx_q +: 4] = s_sum;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      idx_q    <= '0;
      shadow_q <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      sum_o    <= '0;
      cy_out_o <= 1'b0;
      ovf_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (accept) begin
        a_q     <= a_i;
        b_q     <= b_i;
        c_q     <= cy_in_i;
        idx_q   <= '0;
        busy_o  <= 1'b1;
        state_q <= RUN;
      end else if (state_q == RUN) begin
        shadow_q <= shadow_d;
        c_q      <= s_co;
        idx_q    <= last ? '0 : idx_q + IW'(1);
        if (last) begin
          sum_o    <= shadow_d;
          cy_out_o <= s_co;
          ovf_o    <= ovf_d;
          busy_o   <= 1'b0;
          done_o   <= 1'b1;
          state_q  <= DONE;
        end
      end else begin
        state_q <= IDLE;
      end
    end
  end
endmodule
